// File: rtl/jstk_spi_if.sv
// SPI bus between the PmodJSTK reader (master) and the joystick (slave).
interface jstk_spi_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (
        output ss,
        output sclk,
        output mosi,
        input  miso
    );

    modport slave (
        input  ss,
        input  sclk,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/jstk_spi_reader.sv
// Periodic PmodJSTK poller: five-byte SPI mode-0 transfer, X/Y/buttons
// published together once the whole frame has been received.
module jstk_spi_reader #(
    parameter int SCLK_HALF   = 400,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] leds,
    jstk_spi_if.master spi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] buttons,
    output logic       sample_valid,
    output logic       busy
);
    localparam int CW = $clog2(POLL_PERIOD + 1);
    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] poll_cnt, cnt, cnt_last;
    logic [2:0]    bit_cnt, byte_cnt;
    logic [7:0]    tx, rx, x_lo, y_lo, cmd;
    logic [1:0]    x_hi, y_hi;
    logic [2:0]    btn;
    logic          ss_q, sclk_q;
    logic          wrap, cnt_done, byte_end;

    // tx drains to zero after eight shifts, so its MSB is the MOSI line
    assign spi.ss   = ss_q;
    assign spi.sclk = sclk_q;
    assign spi.mosi = tx[7];

    assign cmd      = {6'b100000, leds};
    assign wrap     = poll_cnt == POLL_LAST;
    assign cnt_done = cnt == cnt_last;
    assign byte_end = (state == SHIFT) && sclk_q && cnt_done
                      && (bit_cnt == 3'd7);

    always_comb begin
        cnt_last = '0;
        unique case (state)
            SETUP:       cnt_last = SETUP_LAST;
            GAP:         cnt_last = GAP_LAST;
            SHIFT, DONE: cnt_last = HALF_LAST;
            default:     cnt_last = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (wrap) state_n = SETUP;
            SETUP: if (cnt_done) state_n = SHIFT;
            SHIFT: if (byte_end)
                       state_n = (byte_cnt == 3'd4) ? DONE : GAP;
            GAP:   if (cnt_done) state_n = SHIFT;
            DONE:  if (cnt_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            poll_cnt     <= '0;
            cnt          <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            tx           <= '0;
            rx           <= '0;
            x_lo         <= '0;
            x_hi         <= '0;
            y_lo         <= '0;
            y_hi         <= '0;
            btn          <= '0;
            ss_q         <= 1'b1;
            sclk_q       <= 1'b0;
            busy         <= 1'b0;
            joy_x        <= 10'd512;
            joy_y        <= 10'd512;
            buttons      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            poll_cnt     <= wrap ? '0 : poll_cnt + CW'(1);
            cnt          <= cnt_done ? '0 : cnt + CW'(1);
            unique case (state)
                IDLE: if (wrap) begin
                    tx       <= cmd;
                    ss_q     <= 1'b0;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                SETUP: ;
                SHIFT: if (cnt_done) begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                        rx     <= {rx[6:0], spi.miso};
                    end else begin
                        sclk_q  <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        tx      <= {tx[6:0], 1'b0};
                    end
                end
                GAP: if (cnt_done) tx <= 8'h00;
                DONE: if (cnt_done) begin
                    ss_q         <= 1'b1;
                    busy         <= 1'b0;
                    joy_x        <= {x_hi, x_lo};
                    joy_y        <= {y_hi, y_lo};
                    buttons      <= btn;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
            // Byte slots: b0=X low, b1=X high, b2=Y low, b3=Y high, b4=buttons
            if (byte_end) begin
                byte_cnt <= byte_cnt + 3'd1;
                unique case (byte_cnt)
                    3'd0:    x_lo <= rx;
                    3'd1:    x_hi <= rx[1:0];
                    3'd2:    y_lo <= rx;
                    3'd3:    y_hi <= rx[1:0];
                    3'd4:    btn  <= rx[2:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jstk_spi_reader.sv
// Scoreboard bench for jstk_spi_reader with a behavioural PmodJSTK slave.
module tb_jstk_spi_reader;
    localparam int H = 4;
    localparam int S = 10;
    localparam int G = 8;
    localparam int P = 1000;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] leds = 2'b00;
    logic [9:0] joy_x, joy_y;
    logic [2:0] buttons;
    logic       sample_valid, busy;

    jstk_spi_if spi ();

    jstk_spi_reader #(
        .SCLK_HALF(H), .SS_SETUP(S), .BYTE_GAP(G), .POLL_PERIOD(P)
    ) dut (
        .clk(clk), .clr(clr), .leds(leds), .spi(spi.master),
        .joy_x(joy_x), .joy_y(joy_y), .buttons(buttons),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got,
                         input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur in time", name);
    endtask

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
    } samp_t;

    samp_t       exp_q[$];
    logic [39:0] plan_q[$];
    logic [39:0] cur = '0;
    logic [39:0] mosi_cap = '0;
    logic [39:0] exp_mosi = '0;
    int          rises = 0;
    int          n_samples = 0;
    bit          aborted = 1'b0;

    // Joystick frame as numbers: position = high byte mod 4 times 256 + low byte
    function automatic samp_t model(input logic [39:0] frame);
        int    b[5];
        samp_t r;
        for (int i = 0; i < 5; i++) b[i] = int'(frame[39-8*i -: 8]);
        r.x = 10'((b[1] % 4) * 256 + b[0]);
        r.y = 10'((b[3] % 4) * 256 + b[2]);
        r.b = 3'(b[4] % 8);
        return r;
    endfunction

    always @(negedge spi.ss) if (!clr) begin
        cur = (plan_q.size() != 0) ? plan_q.pop_front()
                                   : {$urandom, 8'($urandom)};
        exp_q.push_back(model(cur));
        exp_mosi = {8'h80 + 8'(leds), 32'h0};
        rises    = 0;
        mosi_cap = '0;
        spi.miso = cur[39];
    end

    always @(posedge spi.sclk) if (!clr) begin
        mosi_cap = {mosi_cap[38:0], spi.mosi};
        rises++;
        spi.miso = (rises < 40) ? cur[39-rises] : 1'b0;
    end

    always @(posedge spi.ss) if (!clr && !aborted) begin
        check("rises_per_tx", rises, 40);
        check("mosi_bytes", mosi_cap, exp_mosi);
    end

    longint cyc = 0;
    longint t_fall = 0, t_rise = -1, t_start = 0;
    bit     start_valid = 1'b0;
    logic   prev_ss = 1'b1, prev_sclk = 1'b0, prev_sv = 1'b0;
    int     n_short = 0, n_long = 0;
    samp_t  s;

    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            start_valid = 1'b0;
        end else begin
            if (prev_ss && !spi.ss) begin
                if (start_valid) check("start_spacing", cyc - t_start, P);
                start_valid = 1'b1;
                t_start = cyc;
                t_fall  = cyc;
                t_rise  = -1;
                n_short = 0;
                n_long  = 0;
            end
            if (!prev_sclk && spi.sclk) begin
                if (t_rise < 0) check("first_rise", cyc - t_fall, S + H);
                else if (cyc - t_rise == 2*H) n_short++;
                else if (cyc - t_rise == 2*H + G) n_long++;
                else check("rise_spacing", cyc - t_rise, 2*H);
                t_rise = cyc;
            end
            if (!prev_ss && spi.ss && !aborted) begin
                check("ss_low_len", cyc - t_fall, S + 80*H + 4*G + H);
                check("bit_periods", n_short, 35);
                check("byte_gaps", n_long, 4);
            end
            if (sample_valid) begin
                n_samples++;
                check("sv_single", prev_sv, 0);
                check("ss_at_sample", spi.ss, 1);
                check("busy_at_sample", busy, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_sample: got pulse expected none");
                end else begin
                    s = exp_q.pop_front();
                    check("joy_x", joy_x, s.x);
                    check("joy_y", joy_y, s.y);
                    check("buttons", buttons, s.b);
                end
            end
        end
        prev_ss   = spi.ss;
        prev_sclk = spi.sclk;
        prev_sv   = sample_valid;
    end

    task automatic wait_start();
        int k;
        for (k = 0; k < 2*P; k++) begin
            @(negedge clk);
            if (!spi.ss) break;
        end
        if (k == 2*P) fail_now("wait_start");
    endtask

    task automatic wait_sample();
        int k;
        int n0 = n_samples;
        for (k = 0; k < 2*P; k++) begin
            @(negedge clk);
            if (n_samples != n0) break;
        end
        if (k == 2*P) fail_now("wait_sample");
    endtask

    task automatic wait_rises(input int n);
        int k;
        for (k = 0; k < 2*P; k++) begin
            @(negedge clk);
            if (rises >= n) break;
        end
        if (k == 2*P) fail_now("wait_rises");
    endtask

    task automatic run_tx(input logic [1:0] l_start, input logic [1:0] l_mid);
        leds = l_start;
        wait_start();
        aborted = 1'b0;
        repeat (50) @(negedge clk);
        leds = l_mid;
        wait_sample();
    endtask

    initial begin
        int k;
        int ns;
        spi.miso = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss", spi.ss, 1);
        check("rst_sclk", spi.sclk, 0);
        check("rst_mosi", spi.mosi, 0);
        check("rst_joy_x", joy_x, 512);
        check("rst_joy_y", joy_y, 512);
        check("rst_buttons", buttons, 0);
        check("rst_sv", sample_valid, 0);
        check("rst_busy", busy, 0);

        plan_q.push_back(40'h2C_01_F4_03_05);
        plan_q.push_back(40'hFF_FE_00_FC_F8);

        leds = 2'b11;
        clr  = 1'b0;
        for (k = 1; k <= 2*P; k++) begin
            @(negedge clk);
            if (!spi.ss) break;
        end
        check("first_start", k, P);
        check("busy_in_tx", busy, 1);
        repeat (50) @(negedge clk);
        leds = 2'b00;
        check("pre_sample_x", joy_x, 512);
        check("pre_sample_y", joy_y, 512);
        check("pre_sample_pulses", n_samples, 0);
        wait_sample();

        run_tx(2'b01, 2'b10);

        leds = 2'($urandom);
        wait_start();
        wait_rises(20);
        @(negedge clk);
        aborted = 1'b1;
        clr = 1'b1;
        #1;
        check("clr_ss", spi.ss, 1);
        check("clr_sclk", spi.sclk, 0);
        check("clr_joy_x", joy_x, 512);
        check("clr_joy_y", joy_y, 512);
        check("clr_buttons", buttons, 0);
        check("clr_busy", busy, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        ns  = n_samples;
        clr = 1'b0;
        wait_start();
        aborted = 1'b0;
        check("no_sample_after_clr", n_samples, ns);
        wait_sample();
        check("sample_after_clr", n_samples, ns + 1);

        for (int i = 0; i < 4; i++) run_tx(2'($urandom), 2'($urandom));

        repeat (10) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
